// File: rtl/divider_core.sv
// divider_core: sequential radix-2 restoring signed/unsigned divider emitting {q_neg, quotient, remainder}
module divider_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [2*WIDTH:0]   data_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_sgn;
    logic             r_sgn;
    logic             q_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Operand magnitudes and one restoring step; rem < dvs keeps trial within WIDTH+1 bits
    always_comb begin
        a_mag  = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
        b_mag  = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
        trial  = {rem, quo[WIDTH-1]};
        diff   = {1'b0, trial} - {2'b00, dvs};
        borrow = diff[WIDTH+1];
    end

    // Control FSM and datapath; outputs are loaded only on the edge leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            q_sgn   <= 1'b0;
            r_sgn   <= 1'b0;
            q_neg   <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        ready_o <= 1'b0;
                        cnt     <= '0;
                        if (divisor_i == '0) begin
                            quo   <= ALL_ONES;
                            rem   <= dividend_i;
                            q_neg <= 1'b0;
                            state <= DONE;
                        end else if (signed_i && dividend_i == MIN_NEG && divisor_i == ALL_ONES) begin
                            quo   <= MIN_NEG;
                            rem   <= '0;
                            q_neg <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            dvs   <= b_mag;
                            q_sgn <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                            r_sgn <= signed_i & dividend_i[WIDTH-1];
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~borrow};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    quo   <= q_sgn ? -quo : quo;
                    rem   <= r_sgn ? -rem : rem;
                    q_neg <= q_sgn && (quo != '0);
                    state <= DONE;
                end
                DONE: begin
                    data_o  <= {q_neg, quo, rem};
                    valid_o <= 1'b1;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
